// File: rtl/hazard_ctl.sv
// hazard_ctl: hazard and sequencing controller for the 5-stage WISC pipeline.
//
// Keeps a write scoreboard for the 8-entry register file. The scoreboard holds
// one down-counter per register. The controller stalls the ID instruction while
// any source it reads still has a write in flight. It flushes IF/ID and ID/EX
// when EX resolves a taken branch or jump. It also sequences HALT (a drain phase
// followed by the halted state) and a sticky error shutdown.
//
// Optional build macro:
//   FWD_EN - EX/MEM forwarding is present, so only a load-use pair stalls,
//            and only for one cycle. Without it, every in-flight write stalls
//            its readers.
//
// Parameter:
//   WB_LAT        cycles from ID issue until the value is readable (1..7)
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   id_*          decoded fields of the instruction currently held in ID
//   ex_br_ju_taken taken branch/jump resolved in EX this cycle
//   stall_pc, stall_if_id, bubble_id_ex, flush_if_id  pipeline controls
//   halted, err   processor halted / sticky decode error
//   stall_cnt     saturating count of hazard stall cycles
module hazard_ctl #(
    parameter int WB_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic        id_rs_used,
    input  logic [2:0]  id_rt,
    input  logic        id_rt_used,
    input  logic        id_reg_wr_en,
    input  logic [2:0]  id_wr_reg,
    input  logic        id_is_load,
    input  logic        id_halt,
    input  logic        id_err,
    input  logic        ex_br_ju_taken,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic        halted,
    output logic        err,
    output logic [15:0] stall_cnt
);

    localparam logic [2:0] LAT = 3'(WB_LAT);

    typedef enum logic [1:0] {RUN, DRAIN, HALT, ERR} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt [8];
    logic [7:0]  load;
    logic        rs_busy, rt_busy, haz, iss, all_idle;

    // A source counts as busy while its producer's result is unreachable.
    // With forwarding, only a load issued on the previous cycle is unreachable.
    always_comb begin
`ifdef FWD_EN
        rs_busy = (cnt[id_rs] == LAT) && load[id_rs];
        rt_busy = (cnt[id_rt] == LAT) && load[id_rt];
`else
        rs_busy = (cnt[id_rs] != 3'd0);
        rt_busy = (cnt[id_rt] != 3'd0);
`endif
        haz = id_valid && ((id_rs_used && rs_busy) || (id_rt_used && rt_busy));
        iss = id_valid && !haz && !ex_br_ju_taken && (state == RUN) && !rst;
    end

    // Drain completes only when no write anywhere is still in flight.
    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (cnt[i] != 3'd0) begin
                all_idle = 1'b0;
            end
        end
    end

    // A newly issued write reloads its entry; this overrides the same
    // cycle's decrement. All other live entries count down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= 3'd0;
            end
            load <= 8'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (iss && id_reg_wr_en && (id_wr_reg == 3'(i))) begin
                    cnt[i]  <= LAT;
                    load[i] <= id_is_load;
                end else if (cnt[i] != 3'd0) begin
                    cnt[i] <= cnt[i] - 3'd1;
                end
            end
        end
    end

    // Counts every RUN cycle with a hazard, including the cycles where a
    // flush overrides the stall. The count saturates at the top value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if ((state == RUN) && haz && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // An error takes priority over halt when both are flagged on one
    // issuing instruction. HALT and ERR are left only through reset.
    always_comb begin
        state_next   = state;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        case (state)
            RUN: begin
                if (iss && id_err) begin
                    state_next = ERR;
                end else if (iss && id_halt) begin
                    state_next = DRAIN;
                end
                if (ex_br_ju_taken) begin
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (haz) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            end
            DRAIN: begin
                if (all_idle) begin
                    state_next = HALT;
                end
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
            default: begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
        endcase
        if (rst) begin
            stall_pc     = 1'b0;
            stall_if_id  = 1'b0;
            bubble_id_ex = 1'b0;
            flush_if_id  = 1'b0;
        end
    end

    assign halted = (state == HALT) || (state == ERR);
    assign err    = (state == ERR);

endmodule
